md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers, E stage, beside the ALU.
//  Takes the same forwarded SrcA/SrcB operands as the ALU.
//  MDOut is muxed with ALUOut into the E/M pipeline register.
//  Busy/BusyOrStart drive the hazard unit, which stalls D-stage md instructions.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy is high for MULT/MULTU (and MADD/MADDU)
//  DIV_CYCLES   10  cycles Busy is high for DIV/DIVU
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  MDOP         in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO,
//                        7 MTHI, 8 MTLO, 9 MADD, 10 MADDU (9/10 only with macro)
//  Start        in   1   E-stage instruction is a mult/div (one-cycle pulse)
//  SrcA         in   32  rs operand (forwarded)
//  SrcB         in   32  rt operand (forwarded)
//  Req          in   1   exception/interrupt flush: E instruction is cancelled
//  Busy         out  1   operation in flight (registered)
//  BusyOrStart  out  1   Busy | (Start & ~Req), combinational, to hazard unit
//  HI           out  32  HI register
//  LO           out  32  LO register
//  MDOut        out  32  MFHI→HI, MFLO→LO, else 0 (combinational)
// BEHAVIOUR
//  - Reset: HI=LO=0, Busy=0, counter=0, temp regs=0. Overrides any op in flight.
//  - Accept: Start & ~Busy & ~Req & MDOP in {1,2,3,4,(9,10)}.
//    - On accept: compute and latch tempHI/tempLO.
//    - On accept: cnt <= MULT_CYCLES or DIV_CYCLES.
//  - Busy = (cnt != 0), from a register. It is high for exactly N cycles after the accept edge.
//  - Completion: on the edge where cnt goes 1→0, HI/LO <= temp and Busy falls.
//    New HI/LO are visible in the cycle after Busy falls.
//  - MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
//  - DIV: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
//    - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
//  - DIVU: unsigned quotient/remainder.
//  - Divisor 0 (DIV/DIVU): full Busy period still runs; HI/LO remain unchanged.
//  - Ignored without state change:
//    - Start while Busy.
//    - Start with Req=1, including in the same cycle as Start.
//    - Start with MDOP not a mult/div.
//  - Req while Busy: the op in flight completes normally. It belongs to an older
//    instruction that has already committed.
//  - MTHI/MTLO: HI (or LO) <= SrcA at the edge, if ~Busy & ~Req.
//    - Dropped if Busy, because the hazard unit guarantees no issue then.
//    - If completion and MTxx coincide, completion wins (unreachable by hazard rules).
//  - MFHI/MFLO read current HI/LO with no bypass of temp values.
//  - Widths: 64-bit intermediate product; counter is clog2(max(N))+1 bits.
//  - NONE and unlisted MDOP codes: no effect, MDOut=0.
// CONFIGURATION
//  MDU_MADD_EN defined:
//   - MDOP 9 MADD: {HI,LO} <= {HI,LO} + signed(SrcA*SrcB), mod 2^64.
//   - MDOP 10 MADDU: {HI,LO} <= {HI,LO} + unsigned(SrcA*SrcB), mod 2^64.
//   - The sum uses HI/LO at the accept edge, with MULT_CYCLES latency.
//  MDU_MADD_EN undefined:
//   - MDOP 9/10 behave as NONE; Start with 9/10 is ignored.
// TESTING
//  1. MULT 0xFFFFFFFE × 3 → Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2. MULTU 0xFFFFFFFE × 3 → HI=2, LO=0xFFFFFFFA.
//  3. DIV -7 / 2 → Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  4. DIVU 7 / 0 → Busy high 10 cycles; HI/LO unchanged.
//  5. Start with Req=1 → Busy stays 0; BusyOrStart=0; HI/LO unchanged.
//  6. MTHI 0x1234 while Busy=0 → next cycle MFHI gives MDOut=0x1234.
//  7. MTLO issued while Busy → LO unchanged.
//  8. Reset at cycle 3 of a DIV → Busy=0, HI=LO=0 next cycle; no late writeback.
//  9. MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1×1 → HI=1, LO=0 after 5 cycles.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the E-stage ALU.
// Optional MADD/MADDU support is enabled by defining MDU_MADD_EN.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOP,
  input  logic        Start,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Req,
  output logic        Busy,
  output logic        BusyOrStart,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8,
    OpMadd  = 4'd9,
    OpMaddu = 4'd10
  } mdOpE;

  logic [CntW-1:0] cnt;
  logic [31:0]     tempHi, tempLo;
  logic            skipWb;

  logic        isMul, isDiv, accept, divSigned;
  logic [63:0] prodS, prodU, nextTemp;
  logic [31:0] magA, magB, divisor, quo, rem, quoOut, remOut;
  logic        negA, negB;

  always_comb begin
    isMul = (MDOP == OpMult) || (MDOP == OpMultu);
`ifdef MDU_MADD_EN
    isMul = isMul || (MDOP == OpMadd) || (MDOP == OpMaddu);
`endif
    isDiv  = (MDOP == OpDiv) || (MDOP == OpDivu);
    accept = Start && !Busy && !Req && (isMul || isDiv);
  end

  assign BusyOrStart = Busy | (Start & ~Req);

  always_comb begin
    prodS = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
    prodU = {32'd0, SrcA} * {32'd0, SrcB};
  end

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    divSigned = (MDOP == OpDiv);
    negA      = divSigned && SrcA[31];
    negB      = divSigned && SrcB[31];
    magA      = negA ? (~SrcA + 32'd1) : SrcA;
    magB      = negB ? (~SrcB + 32'd1) : SrcB;
    divisor   = (magB == 32'd0) ? 32'd1 : magB;
    quo       = magA / divisor;
    rem       = magA % divisor;
    quoOut    = (negA ^ negB) ? (~quo + 32'd1) : quo;
    remOut    = negA ? (~rem + 32'd1) : rem;
  end

  always_comb begin
    nextTemp = 64'd0;
    case (MDOP)
      OpMult:  nextTemp = prodS;
      OpMultu: nextTemp = prodU;
      OpDiv,
      OpDivu:  nextTemp = {remOut, quoOut};
`ifdef MDU_MADD_EN
      OpMadd:  nextTemp = {HI, LO} + prodS;
      OpMaddu: nextTemp = {HI, LO} + prodU;
`endif
      default: nextTemp = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI     <= 32'd0;
      LO     <= 32'd0;
      Busy   <= 1'b0;
      cnt    <= '0;
      tempHi <= 32'd0;
      tempLo <= 32'd0;
      skipWb <= 1'b0;
    end else if (Busy) begin
      // Op in flight owns HI/LO; new starts and MTxx are dropped until it retires.
      cnt <= cnt - 1'b1;
      if (cnt == CntW'(1)) begin
        Busy <= 1'b0;
        if (!skipWb) begin
          HI <= tempHi;
          LO <= tempLo;
        end
      end
    end else if (accept) begin
      tempHi <= nextTemp[63:32];
      tempLo <= nextTemp[31:0];
      skipWb <= isDiv && (SrcB == 32'd0);
      cnt    <= isDiv ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
      Busy   <= 1'b1;
    end else if (!Req) begin
      if (MDOP == OpMthi) HI <= SrcA;
      if (MDOP == OpMtlo) LO <= SrcA;
    end
  end

  always_comb begin
    case (MDOP)
      OpMfhi:  MDOut = HI;
      OpMflo:  MDOut = LO;
      default: MDOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops against
// a cycle-level arithmetic reference model.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDOP;
  logic        Start;
  logic [31:0] SrcA, SrcB;
  logic        Req;
  logic        Busy, BusyOrStart;
  logic [31:0] HI, LO, MDOut;

  md_unit #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MDOP       (MDOP),
    .Start      (Start),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .Req        (Req),
    .Busy       (Busy),
    .BusyOrStart(BusyOrStart),
    .HI         (HI),
    .LO         (LO),
    .MDOut      (MDOut)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // Reference state: architectural HI/LO plus the pending result and cycles left.
  logic [31:0] mHi = 0, mLo = 0, pHi = 0, pLo = 0;
  bit          pValid = 0;
  int          mLeft = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit isMdOp(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || op == 4'd9 || op == 4'd10;
`else
    return op >= 4'd1 && op <= 4'd4;
`endif
  endfunction

  function automatic void refCompute(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output bit ok,
                                     output logic [63:0] res);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok  = 1;
    res = 64'd0;
    case (op)
      4'd1: res = 64'(sa * sb);
      4'd2: res = ua * ub;
      4'd3: begin
        if (b == 0) ok = 0;
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        if (b == 0) ok = 0;
        else res = {a % b, a / b};
      end
      4'd9:  res = {mHi, mLo} + 64'(sa * sb);
      4'd10: res = {mHi, mLo} + ua * ub;
      default: ok = 0;
    endcase
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance model, check state.
  task automatic step(input logic [3:0] op, input bit st, input logic [31:0] a,
                      input logic [31:0] b, input bit rq, input bit rst);
    logic [31:0] expOut;
    logic [63:0] res;
    bit ok;
    MDOP = op; Start = st; SrcA = a; SrcB = b; Req = rq; reset = rst;
    #1;
    expOut = (op == 4'd5) ? mHi : (op == 4'd6) ? mLo : 32'd0;
    if (!rst) begin
      check("MDOut", {32'd0, MDOut}, {32'd0, expOut});
      check("BusyOrStart", {63'd0, BusyOrStart}, {63'd0, (mLeft > 0) || (st && !rq)});
    end
    @(posedge clk);
    if (rst) begin
      mHi = 0; mLo = 0; mLeft = 0; pValid = 0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0 && pValid) begin
        mHi = pHi; mLo = pLo;
      end
    end else if (st && !rq && isMdOp(op)) begin
      refCompute(op, a, b, ok, res);
      pValid = ok;
      pHi = res[63:32];
      pLo = res[31:0];
      mLeft = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
    end else if (!rq) begin
      if (op == 4'd7) mHi = a;
      if (op == 4'd8) mLo = a;
    end
    @(negedge clk);
    check("Busy", {63'd0, Busy}, {63'd0, mLeft > 0});
    check("HI", {32'd0, HI}, {32'd0, mHi});
    check("LO", {32'd0, LO}, {32'd0, mLo});
  endtask

  // Issue a start, then idle until the DUT drops Busy (bounded), returning Busy cycles seen.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busyCycles);
    busyCycles = 0;
    step(op, 1, a, b, 0, 0);
    for (int i = 0; i < 20 && Busy; i++) begin
      busyCycles++;
      step(4'd0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int n;
    logic [3:0] op;
    logic [31:0] a, b;
    MDOP = 0; Start = 0; SrcA = 0; SrcB = 0; Req = 0; reset = 1;
    @(negedge clk);
    step(4'd0, 0, 0, 0, 0, 1);
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);

    // 1. MULT signed
    runOp(4'd1, 32'hFFFFFFFE, 32'd3, n);
    check("t1_busy_len", 64'(n), 64'(MULT_N));
    check("t1_hilo", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFA});
    // 2. MULTU
    runOp(4'd2, 32'hFFFFFFFE, 32'd3, n);
    check("t2_hilo", {HI, LO}, {32'd2, 32'hFFFFFFFA});
    // 3. DIV -7 / 2
    runOp(4'd3, 32'hFFFFFFF9, 32'd2, n);
    check("t3_busy_len", 64'(n), 64'(DIV_N));
    check("t3_hilo", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    // DIV overflow corner
    runOp(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    check("ovf_hilo", {HI, LO}, {32'd0, 32'h80000000});
    // 4. DIVU by zero leaves HI/LO
    step(4'd7, 0, 32'hAAAA5555, 0, 0, 0);
    runOp(4'd4, 32'd7, 32'd0, n);
    check("t4_busy_len", 64'(n), 64'(DIV_N));
    check("t4_hilo", {HI, LO}, {32'hAAAA5555, 32'h80000000});
    // 5. Start with Req
    step(4'd1, 1, 32'd9, 32'd9, 1, 0);
    check("t5_busy", {63'd0, Busy}, 64'd0);
    check("t5_hilo", {HI, LO}, {32'hAAAA5555, 32'h80000000});
    // 6. MTHI then MFHI
    step(4'd7, 0, 32'h1234, 0, 0, 0);
    step(4'd5, 0, 0, 0, 0, 0);
    check("t6_hi", {32'd0, HI}, 64'h1234);
    // 7. MTLO while busy is dropped
    step(4'd2, 1, 32'd6, 32'd7, 0, 0);
    step(4'd8, 0, 32'hDEAD, 0, 0, 0);
    for (int i = 0; i < MULT_N; i++) step(4'd0, 0, 0, 0, 0, 0);
    check("t7_lo", {32'd0, LO}, 64'd42);
    // 8. Reset mid-DIV, no late writeback
    step(4'd3, 1, 32'd100, 32'd3, 0, 0);
    step(4'd0, 0, 0, 0, 0, 0);
    step(4'd0, 0, 0, 0, 0, 0);
    step(4'd0, 0, 0, 0, 0, 1);
    check("t8_busy", {63'd0, Busy}, 64'd0);
    check("t8_hilo", {HI, LO}, 64'd0);
    for (int i = 0; i < DIV_N + 2; i++) step(4'd0, 0, 0, 0, 0, 0);
    check("t8_late", {HI, LO}, 64'd0);
`ifdef MDU_MADD_EN
    // 9. MADDU carry into HI
    step(4'd8, 0, 32'hFFFFFFFF, 0, 0, 0);
    runOp(4'd10, 32'd1, 32'd1, n);
    check("t9_busy_len", 64'(n), 64'(MULT_N));
    check("t9_hilo", {HI, LO}, {32'd1, 32'd0});
`else
    // MADDU start is ignored without the feature
    step(4'd10, 1, 32'd1, 32'd1, 0, 0);
    check("t9_ignored", {63'd0, Busy}, 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom;
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      step(op, $urandom_range(0, 2) != 0, a, b, $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
